// File: rtl/poly_voice_engine.sv
// Multi-voice DDS sine engine: voices share one quarter-wave sine table and one multiplier,
// stepping each voice's envelope once per audio frame and summing into one saturated sample.
module poly_voice_engine #(
  parameter int NUM_VOICES   = 4,
  parameter int PHASE_W      = 32,
  parameter int OUT_W        = 16,
  parameter int ENV_W        = 8,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 2,
  localparam int CV_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  AUD_DACLRCK,
  input  logic                  sample_tick,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CV_W-1:0]       cmd_voice,
  input  logic [PHASE_W-1:0]    cmd_incr,
  output logic [OUT_W-1:0]      mix_out,
  output logic                  mix_valid,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  overrun
);

  localparam int VCNT_W = $clog2(NUM_VOICES + 1);
  localparam int ACC_W  = OUT_W + $clog2(NUM_VOICES) + 1;
  localparam logic [ENV_W-1:0] ENV_FULL = '1;
  localparam logic [ENV_W:0]   ATK = (ENV_W + 1)'(ATTACK_STEP);
  localparam logic [ENV_W:0]   REL = (ENV_W + 1)'(RELEASE_STEP);
  localparam logic signed [ACC_W-1:0] MIX_MAX = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIX_MIN = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  // First quadrant of a 256-point sine, amplitude 32767; entry 64 is the peak.
  localparam logic [14:0] QTAB [65] = '{
    15'd0,     15'd804,   15'd1608,  15'd2410,  15'd3212,  15'd4011,  15'd4808,  15'd5602,
    15'd6393,  15'd7179,  15'd7962,  15'd8739,  15'd9512,  15'd10278, 15'd11039, 15'd11793,
    15'd12539, 15'd13279, 15'd14010, 15'd14732, 15'd15446, 15'd16151, 15'd16846, 15'd17530,
    15'd18204, 15'd18868, 15'd19519, 15'd20159, 15'd20787, 15'd21403, 15'd22005, 15'd22594,
    15'd23170, 15'd23731, 15'd24279, 15'd24811, 15'd25329, 15'd25832, 15'd26319, 15'd26790,
    15'd27245, 15'd27683, 15'd28105, 15'd28510, 15'd28898, 15'd29268, 15'd29621, 15'd29956,
    15'd30273, 15'd30571, 15'd30852, 15'd31113, 15'd31356, 15'd31580, 15'd31785, 15'd31971,
    15'd32137, 15'd32285, 15'd32412, 15'd32521, 15'd32609, 15'd32678, 15'd32728, 15'd32757,
    15'd32767
  };

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_FLUSH} top_state_t;
  typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} voice_state_t;

  top_state_t state, state_next;
  voice_state_t vstate [NUM_VOICES];
  logic [PHASE_W-1:0] phase [NUM_VOICES];
  logic [PHASE_W-1:0] incr  [NUM_VOICES];
  logic [ENV_W-1:0]   env   [NUM_VOICES];

  logic [VCNT_W-1:0] vidx;
  logic signed [ACC_W-1:0] acc, prod_q, prod_term;
  logic [OUT_W-1:0] mix_sat;

  voice_state_t sel_state, nxt_state;
  logic [PHASE_W-1:0] sel_phase, sel_incr, nxt_phase;
  logic [ENV_W-1:0] sel_env, nxt_env;
  logic [ENV_W:0] env_up;
  logic [7:0] sidx;
  logic [6:0] qk, qaddr;
  logic [14:0] mag;
  logic signed [OUT_W-1:0] sine_mag, sine;
  logic signed [OUT_W+ENV_W:0] prod_full;
  logic signed [OUT_W:0] prod_narrow;

  always_ff @(posedge clk or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) state <= S_IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (sample_tick) state_next = S_PASS;
      end
      S_PASS:  if (vidx == VCNT_W'(NUM_VOICES)) state_next = S_FLUSH;
      S_FLUSH: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sel_state = V_IDLE;
    sel_phase = '0;
    sel_incr  = '0;
    sel_env   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (VCNT_W'(i) == vidx) begin
        sel_state = vstate[i];
        sel_phase = phase[i];
        sel_incr  = incr[i];
        sel_env   = env[i];
      end
    end
  end

  // Sine lookup, gain and envelope step for the voice being processed this cycle.
  always_comb begin
    sidx        = sel_phase[PHASE_W-1 -: 8];
    qk          = {1'b0, sidx[5:0]};
    qaddr       = sidx[6] ? (7'd64 - qk) : qk;
    mag         = QTAB[qaddr];
    sine_mag    = OUT_W'(mag);
    sine        = sidx[7] ? -sine_mag : sine_mag;
    prod_full   = sine * $signed({1'b0, sel_env});
    prod_narrow = (OUT_W + 1)'(prod_full >>> ENV_W);
    prod_term   = (sel_state == V_IDLE) ? '0 : ACC_W'(prod_narrow);
    env_up      = {1'b0, sel_env} + ATK;
    nxt_state   = sel_state;
    nxt_env     = sel_env;
    nxt_phase   = sel_phase + sel_incr;
    case (sel_state)
      V_IDLE: nxt_phase = sel_phase;
      V_ATTACK: begin
        if (env_up >= {1'b0, ENV_FULL}) begin
          nxt_env   = ENV_FULL;
          nxt_state = V_SUSTAIN;
        end else begin
          nxt_env = env_up[ENV_W-1:0];
        end
      end
      V_RELEASE: begin
        if ({1'b0, sel_env} <= REL) begin
          nxt_env   = '0;
          nxt_state = V_IDLE;
          nxt_phase = '0;
        end else begin
          nxt_env = sel_env - REL[ENV_W-1:0];
        end
      end
      default: nxt_env = sel_env;
    endcase
  end

  // Commands only land in IDLE and passes only in PASS, so a voice never sees both at once.
  always_ff @(posedge clk or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        vstate[i] <= V_IDLE;
        phase[i]  <= '0;
        incr[i]   <= '0;
        env[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (cmd_valid && cmd_ready && cmd_voice == CV_W'(i)) begin
          if (cmd_incr != '0) begin
            incr[i] <= cmd_incr;
            if (vstate[i] == V_IDLE) begin
              vstate[i] <= V_ATTACK;
              env[i]    <= '0;
              phase[i]  <= '0;
            end else if (vstate[i] == V_RELEASE) begin
              vstate[i] <= V_ATTACK;
            end
          end else if (vstate[i] == V_ATTACK || vstate[i] == V_SUSTAIN) begin
            vstate[i] <= V_RELEASE;
          end
        end else if (state == S_PASS && vidx == VCNT_W'(i)) begin
          vstate[i] <= nxt_state;
          phase[i]  <= nxt_phase;
          env[i]    <= nxt_env;
        end
      end
    end
  end

  always_comb begin
    if (acc > MIX_MAX)      mix_sat = MIX_MAX[OUT_W-1:0];
    else if (acc < MIX_MIN) mix_sat = MIX_MIN[OUT_W-1:0];
    else                    mix_sat = acc[OUT_W-1:0];
  end

  // Products are registered one cycle before accumulation, so one drain step follows the last voice.
  always_ff @(posedge clk or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) begin
      vidx      <= '0;
      acc       <= '0;
      prod_q    <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (sample_tick && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            vidx   <= '0;
            acc    <= '0;
            prod_q <= '0;
          end
        end
        S_PASS: begin
          acc <= acc + prod_q;
          if (vidx != VCNT_W'(NUM_VOICES)) begin
            prod_q <= prod_term;
            vidx   <= vidx + 1'b1;
          end
        end
        S_FLUSH: begin
          mix_out   <= mix_sat;
          mix_valid <= 1'b1;
        end
        default: mix_valid <= 1'b0;
      endcase
    end
  end

  always_comb begin
    voice_active = '0;
    for (int i = 0; i < NUM_VOICES; i++) voice_active[i] = (vstate[i] != V_IDLE);
  end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Scoreboard bench for poly_voice_engine: a real-valued sine/envelope model predicts every mixed
// sample, its arrival edge and the active-voice mask; a monitor checks them as mix_valid appears.
module tb_poly_voice_engine;

  localparam int NV      = 4;
  localparam int PHASE_W = 32;
  localparam int OUT_W   = 16;
  localparam int ENV_W   = 8;
  localparam int ATK     = 8;
  localparam int RELS    = 2;
  localparam int FULL    = 255;
  localparam int CV_W    = (NV > 1) ? $clog2(NV) : 1;
  localparam int TOL     = NV;
  localparam int M_IDLE = 0, M_ATK = 1, M_SUS = 2, M_REL = 3;

  logic clk = 1'b0;
  logic AUD_DACLRCK = 1'b0;
  logic sample_tick = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [CV_W-1:0] cmd_voice = '0;
  logic [PHASE_W-1:0] cmd_incr = '0;
  logic [OUT_W-1:0] mix_out;
  logic mix_valid;
  logic [NV-1:0] voice_active;
  logic overrun;

  poly_voice_engine #(
    .NUM_VOICES(NV), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .ENV_W(ENV_W),
    .ATTACK_STEP(ATK), .RELEASE_STEP(RELS)
  ) dut (
    .clk(clk), .AUD_DACLRCK(AUD_DACLRCK), .sample_tick(sample_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_voice(cmd_voice),
    .cmd_incr(cmd_incr), .mix_out(mix_out), .mix_valid(mix_valid),
    .voice_active(voice_active), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mix;
    longint edge_no;
    logic [NV-1:0] act;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  longint cyc = 0;
  longint last_tick = -1000;

  int m_st [NV];
  int m_env [NV];
  logic [PHASE_W-1:0] m_phase [NV];
  logic [PHASE_W-1:0] m_incr [NV];
  bit m_overrun;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input longint act, input longint req, input int tol);
    longint d;
    d = act - req;
    n_cmp++;
    if (d > tol || d < -tol) begin
      n_bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sine_ref(input int idx);
    real s;
    s = 32767.0 * $sin(2.0 * 3.141592653589793 * idx / 256.0);
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_st[v] = M_IDLE; m_env[v] = 0; m_phase[v] = '0; m_incr[v] = '0;
    end
    m_overrun = 0;
    last_tick = -1000;
    sbq.delete();
  endtask

  task automatic model_cmd(input int v, input logic [PHASE_W-1:0] inc);
    if (v >= NV) return;
    if (inc != 0) begin
      m_incr[v] = inc;
      if (m_st[v] == M_IDLE) begin
        m_st[v] = M_ATK; m_env[v] = 0; m_phase[v] = '0;
      end else if (m_st[v] == M_REL) begin
        m_st[v] = M_ATK;
      end
    end else if (m_st[v] == M_ATK || m_st[v] == M_SUS) begin
      m_st[v] = M_REL;
    end
  endtask

  // One frame: each sounding voice adds floor(sine*env/256), then its envelope and phase move on.
  task automatic model_pass(input longint e);
    exp_t x;
    int sum;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_st[v] != M_IDLE) begin
        sum += $rtoi($floor(real'(sine_ref(int'(m_phase[v][PHASE_W-1 -: 8])) * m_env[v]) / 256.0));
        m_phase[v] = m_phase[v] + m_incr[v];
        if (m_st[v] == M_ATK) begin
          m_env[v] = (m_env[v] + ATK > FULL) ? FULL : m_env[v] + ATK;
          if (m_env[v] == FULL) m_st[v] = M_SUS;
        end else if (m_st[v] == M_REL) begin
          m_env[v] = (m_env[v] - RELS < 0) ? 0 : m_env[v] - RELS;
          if (m_env[v] == 0) begin
            m_st[v] = M_IDLE;
            m_phase[v] = '0;
          end
        end
      end
    end
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    x.mix = sum;
    x.edge_no = e + NV + 2;
    for (int v = 0; v < NV; v++) x.act[v] = (m_st[v] != M_IDLE);
    sbq.push_back(x);
  endtask

  // Called just after a falling edge; drives one rising edge and returns after the next falling edge.
  task automatic apply_stimulus(input bit tick, input bit cv, input int voice, input logic [PHASE_W-1:0] inc);
    longint e;
    bit idle;
    sample_tick = tick;
    cmd_valid = cv;
    cmd_voice = CV_W'(voice);
    cmd_incr = inc;
    e = cyc + 1;
    idle = (e > last_tick + NV + 2);
    check_output("cmd_ready", longint'(cmd_ready), longint'(idle), 0);
    if (cv && idle) model_cmd(voice, inc);
    if (tick) begin
      if (idle) begin
        model_pass(e);
        last_tick = e;
      end else begin
        m_overrun = 1;
      end
    end
    @(negedge clk);
    sample_tick = 1'b0;
    cmd_valid = 1'b0;
    check_output("overrun", longint'(overrun), longint'(m_overrun), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, '0);
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1, 0, 0, '0);
      idle_cycles(gap - 1);
    end
  endtask

  task automatic do_reset();
    AUD_DACLRCK = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    AUD_DACLRCK = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mix_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_mix_valid: actual mix_out=%0d required=no sample", $signed(mix_out));
      end else begin
        mon_e = sbq.pop_front();
        check_output("mix_out", longint'($signed(mix_out)), longint'(mon_e.mix), TOL);
        check_output("mix_latency_edge", cyc, mon_e.edge_no, 0);
        check_output("voice_active", longint'(voice_active), longint'(mon_e.act), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_output("reset_mix_out", longint'(mix_out), 0, 0);
    check_output("reset_mix_valid", longint'(mix_valid), 0, 0);
    check_output("reset_cmd_ready", longint'(cmd_ready), 1, 0);
    check_output("reset_voice_active", longint'(voice_active), 0, 0);
    check_output("reset_overrun", longint'(overrun), 0, 0);
    AUD_DACLRCK = 1'b1;
    @(negedge clk);

    $display("[TB] reset during a pass");
    apply_stimulus(0, 1, 0, 32'h0100_0000);
    run_ticks(3, 10);
    apply_stimulus(1, 0, 0, '0);
    idle_cycles(2);
    AUD_DACLRCK = 1'b0;
    #1;
    check_output("midpass_mix_valid", longint'(mix_valid), 0, 0);
    check_output("midpass_cmd_ready", longint'(cmd_ready), 1, 0);
    check_output("midpass_voice_active", longint'(voice_active), 0, 0);
    check_output("midpass_mix_out", longint'(mix_out), 0, 0);
    model_reset();
    repeat (NV + 4) @(negedge clk);
    AUD_DACLRCK = 1'b1;
    @(negedge clk);
    run_ticks(1, NV + 4);

    $display("[TB] single voice attack and sustain");
    apply_stimulus(0, 1, 0, 32'h0100_0000);
    run_ticks(40, 64);

    $display("[TB] release to idle");
    apply_stimulus(0, 1, 0, '0);
    run_ticks(132, 8);

    $display("[TB] four voices at the sine peak");
    for (int v = 0; v < NV; v++) apply_stimulus(0, 1, v, 32'h4000_0000);
    run_ticks(40, 8);

    $display("[TB] overrun");
    apply_stimulus(1, 0, 0, '0);
    apply_stimulus(1, 0, 0, '0);
    idle_cycles(NV + 4);
    run_ticks(2, 8);

    $display("[TB] command with tick, re-attack from release");
    do_reset();
    @(negedge clk);
    apply_stimulus(1, 1, 1, 32'h0200_0000);
    idle_cycles(NV + 4);
    apply_stimulus(0, 1, 2, 32'h0080_0000);
    run_ticks(13, 8);
    apply_stimulus(0, 1, 2, '0);
    run_ticks(2, 8);
    apply_stimulus(0, 1, 2, 32'h0300_0000);
    run_ticks(6, 8);
    apply_stimulus(0, 1, 1, 32'h0500_0000);
    run_ticks(3, 8);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                     int'($urandom_range(0, (1 << CV_W) - 1)),
                     ($urandom_range(0, 3) == 0) ? 32'h0 : PHASE_W'($urandom));
    end

    for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL drain: actual=%0d samples outstanding required=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
